// File: rtl/pzcorebus_memory_responder.sv
// -----------------------------------------------------------------------------
// pzcorebus_memory_responder
//
// Purpose:
//   Command-consuming, response-producing end of a pzcorebus link backed by a
//   small word-addressed memory. One command is processed at a time:
//     READ             -> length+1 READ_DATA beats
//     WRITE (posted)   -> length+1 data beats consumed, no response
//     WRITE_NON_POSTED -> data beats consumed, then one WRITE_ACK beat
//     reserved (3)     -> accepted, answered with one WRITE_ACK carrying an error
//   A write burst ends early if the master marks a beat with i_mdata_last.
//
// Ports:
//   i_clk, i_rst                   clock (rising edge), async active-high reset
//   i_mcmd_valid / o_scmd_accept   command channel handshake
//   i_mcmd, i_maddr, i_mlength,    command fields (type, word address,
//   i_mid                          beats minus 1, transaction id)
//   i_mdata_valid / o_sdata_accept write data channel handshake
//   i_mdata, i_mdata_last          write data beat and early-end marker
//   o_sresp_valid / i_mresp_accept response channel handshake
//   o_sresp, o_sid, o_serror,      response type (0 READ_DATA, 1 WRITE_ACK),
//   o_sdata, o_sresp_last          id, error flag, read data, last beat
//
// Build option:
//   PZCOREBUS_MEMORY_RESPONDER_ERROR_CHECK_EN
//     When defined, a command whose addr+length reaches past the last word is
//     flagged: write beats are consumed but discarded, read beats return zero,
//     and every response beat carries o_serror=1. When undefined, addresses
//     simply wrap modulo WORDS.
// -----------------------------------------------------------------------------
module pzcorebus_memory_responder #(
    parameter int WORDS      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // command channel
    input  logic                  i_mcmd_valid,
    output logic                  o_scmd_accept,
    input  logic [1:0]            i_mcmd,
    input  logic [7:0]            i_maddr,
    input  logic [3:0]            i_mlength,
    input  logic [ID_WIDTH-1:0]   i_mid,
    // write data channel
    input  logic                  i_mdata_valid,
    output logic                  o_sdata_accept,
    input  logic [DATA_WIDTH-1:0] i_mdata,
    input  logic                  i_mdata_last,
    // response channel
    output logic                  o_sresp_valid,
    input  logic                  i_mresp_accept,
    output logic                  o_sresp,
    output logic [ID_WIDTH-1:0]   o_sid,
    output logic                  o_serror,
    output logic [DATA_WIDTH-1:0] o_sdata,
    output logic                  o_sresp_last
);

    // Word index width; addresses wrap modulo WORDS, so only the low AW bits
    // of (addr + beat) ever select a word.
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] CMD_READ     = 2'd0;
    localparam logic [1:0] CMD_WRITE    = 2'd1;
    localparam logic [1:0] CMD_WRITE_NP = 2'd2;

    localparam logic RESP_READ_DATA = 1'b0;
    localparam logic RESP_WRITE_ACK = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_WRITE_RESP = 2'd2,
        ST_READ       = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [3:0]            length_q, length_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [3:0]            beat_q, beat_d;
    logic                  err_q, err_d;

    logic                  sresp_valid_q, sresp_valid_d;
    logic                  sresp_q, sresp_d;
    logic [ID_WIDTH-1:0]   sid_q, sid_d;
    logic                  serror_q, serror_d;
    logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
    logic                  sresp_last_q, sresp_last_d;

    // Storage: deliberately not reset.
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  mem_we;
    logic [AW-1:0]         cur_idx;
    logic [AW-1:0]         next_idx;
    logic                  range_err;
    logic                  unused_addr_bits;

    // Word addressed by the current beat, and by the beat after it.
    assign cur_idx  = addr_q + AW'(beat_q);
    assign next_idx = cur_idx + AW'(1);

`ifdef PZCOREBUS_MEMORY_RESPONDER_ERROR_CHECK_EN
    // 9-bit compare so addr=255,length=15 cannot wrap into a false pass.
    assign range_err = (({1'b0, i_maddr} + {5'd0, i_mlength}) >= 9'(WORDS));
`else
    assign range_err = 1'b0;
`endif
    // Upper address bits only matter for the range check.
    assign unused_addr_bits = ^i_maddr;

    // Handshake accepts are pure state decodes.
    assign o_scmd_accept  = (state_q == ST_IDLE);
    assign o_sdata_accept = (state_q == ST_WRITE);

    assign o_sresp_valid = sresp_valid_q;
    assign o_sresp       = sresp_q;
    assign o_sid         = sid_q;
    assign o_serror      = serror_q;
    assign o_sdata       = sdata_q;
    assign o_sresp_last  = sresp_last_q;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        length_d      = length_q;
        id_d          = id_q;
        beat_d        = beat_q;
        err_d         = err_q;
        sresp_valid_d = sresp_valid_q;
        sresp_d       = sresp_q;
        sid_d         = sid_q;
        serror_d      = serror_q;
        sdata_d       = sdata_q;
        sresp_last_d  = sresp_last_q;
        mem_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_mcmd_valid) begin
                    cmd_d    = i_mcmd;
                    addr_d   = i_maddr[AW-1:0];
                    length_d = i_mlength;
                    id_d     = i_mid;
                    beat_d   = 4'd0;
                    err_d    = range_err;
                    case (i_mcmd)
                        CMD_READ: begin
                            // First beat is loaded straight away so it is
                            // valid the cycle after the command is taken.
                            state_d       = ST_READ;
                            sresp_valid_d = 1'b1;
                            sresp_d       = RESP_READ_DATA;
                            sid_d         = i_mid;
                            serror_d      = range_err;
                            sdata_d       = range_err ? '0 : mem[i_maddr[AW-1:0]];
                            sresp_last_d  = (i_mlength == 4'd0);
                        end
                        CMD_WRITE, CMD_WRITE_NP: begin
                            state_d = ST_WRITE;
                        end
                        default: begin
                            // Reserved encoding: no data phase, error ack.
                            state_d       = ST_WRITE_RESP;
                            err_d         = 1'b1;
                            sresp_valid_d = 1'b1;
                            sresp_d       = RESP_WRITE_ACK;
                            sid_d         = i_mid;
                            serror_d      = 1'b1;
                            sdata_d       = '0;
                            sresp_last_d  = 1'b1;
                        end
                    endcase
                end
            end

            ST_WRITE: begin
                if (i_mdata_valid) begin
                    // Out-of-range bursts are drained without touching memory.
                    mem_we = !err_q;
                    beat_d = beat_q + 4'd1;
                    if ((beat_q == length_q) || i_mdata_last) begin
                        if (cmd_q == CMD_WRITE_NP) begin
                            state_d       = ST_WRITE_RESP;
                            sresp_valid_d = 1'b1;
                            sresp_d       = RESP_WRITE_ACK;
                            sid_d         = id_q;
                            serror_d      = err_q;
                            sdata_d       = '0;
                            sresp_last_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            ST_WRITE_RESP: begin
                if (i_mresp_accept) begin
                    state_d       = ST_IDLE;
                    sresp_valid_d = 1'b0;
                    sresp_d       = 1'b0;
                    sid_d         = '0;
                    serror_d      = 1'b0;
                    sresp_last_d  = 1'b0;
                end
            end

            ST_READ: begin
                // Outputs only move on an accepted beat, which keeps them
                // stable through any stall.
                if (i_mresp_accept) begin
                    if (beat_q == length_q) begin
                        state_d       = ST_IDLE;
                        sresp_valid_d = 1'b0;
                        sresp_d       = 1'b0;
                        sid_d         = '0;
                        serror_d      = 1'b0;
                        sdata_d       = '0;
                        sresp_last_d  = 1'b0;
                    end else begin
                        beat_d       = beat_q + 4'd1;
                        sdata_d      = err_q ? '0 : mem[next_idx];
                        sresp_last_d = ((beat_q + 4'd1) == length_q);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            cmd_q         <= 2'd0;
            addr_q        <= '0;
            length_q      <= 4'd0;
            id_q          <= '0;
            beat_q        <= 4'd0;
            err_q         <= 1'b0;
            sresp_valid_q <= 1'b0;
            sresp_q       <= 1'b0;
            sid_q         <= '0;
            serror_q      <= 1'b0;
            sdata_q       <= '0;
            sresp_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            length_q      <= length_d;
            id_q          <= id_d;
            beat_q        <= beat_d;
            err_q         <= err_d;
            sresp_valid_q <= sresp_valid_d;
            sresp_q       <= sresp_d;
            sid_q         <= sid_d;
            serror_q      <= serror_d;
            sdata_q       <= sdata_d;
            sresp_last_q  <= sresp_last_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[cur_idx] <= i_mdata;
        end
    end

endmodule

// File: doc/pzcorebus_memory_responder.md
PZCOREBUS_MEMORY_RESPONDER -- requirements
Module: pzcorebus_memory_responder

Interface
REQ-001 SHALL have parameter WORDS, default 16, meaning number of DATA_WIDTH-bit storage words (power of 2, 2..256).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning write/read data width in bits.
REQ-003 SHALL have parameter ID_WIDTH, default 4, meaning command/response ID width.
REQ-004 SHALL have ports: i_clk input 1 (single clock, all logic rising-edge); i_rst input 1 (reset, asynchronous assert, active-high).
REQ-005 SHALL have ports: i_mcmd_valid input 1; o_scmd_accept output 1; i_mcmd input 2 (0=READ, 1=WRITE posted, 2=WRITE_NON_POSTED, 3=reserved); i_maddr input 8 (word address); i_mlength input 4 (beats minus 1); i_mid input ID_WIDTH.
REQ-006 SHALL have ports: i_mdata_valid input 1; o_sdata_accept output 1; i_mdata input DATA_WIDTH; i_mdata_last input 1.
REQ-007 SHALL have ports: o_sresp_valid output 1; i_mresp_accept input 1; o_sresp output 1 (0=READ_DATA, 1=WRITE_ACK); o_sid output ID_WIDTH; o_serror output 1; o_sdata output DATA_WIDTH; o_sresp_last output 1.

Function
REQ-008 SHALL be the command-consuming, response-producing end of pzcorebus; transfer on any channel occurs only in a cycle where valid and accept are both 1.
REQ-009 SHALL implement FSM IDLE, WRITE, WRITE_RESP, READ; one command in flight at a time.
REQ-010 SHALL assert o_scmd_accept only in IDLE; accepted command latches cmd, addr, length, id, and sets beat counter to 0.
REQ-011 SHALL transition IDLE->WRITE on WRITE/WRITE_NON_POSTED, IDLE->READ on READ; reserved command SHALL be accepted and go to WRITE_RESP with o_serror=1, o_sresp=WRITE_ACK.
REQ-012 SHALL assert o_sdata_accept only in WRITE; each accepted beat stores i_mdata at word (addr+beat) mod WORDS, beat increments by 1.
REQ-013 SHALL end WRITE on the beat where beat==length or i_mdata_last=1, whichever first; extra mdata beats beyond length are not part of this command (next WRITE consumes them).
REQ-014 SHALL go WRITE->IDLE for posted WRITE, WRITE->WRITE_RESP for WRITE_NON_POSTED.
REQ-015 SHALL drive in WRITE_RESP one beat: o_sresp_valid=1, o_sresp=WRITE_ACK, o_sid=latched id, o_sresp_last=1, o_sdata=0; ->IDLE when accepted.
REQ-016 SHALL drive in READ length+1 beats: o_sdata=word (addr+beat) mod WORDS, o_sresp=READ_DATA, o_sid=latched id, o_sresp_last=1 only on beat==length; beat increments per accepted beat; ->IDLE after last beat accepted.
REQ-017 SHALL hold all response outputs stable while o_sresp_valid=1 and i_mresp_accept=0.
REQ-018 SHALL register all outputs except o_scmd_accept/o_sdata_accept (decoded from state); first read beat valid the cycle after command acceptance.
REQ-019 SHALL let a posted WRITE command be accepted the cycle after the final data beat (IDLE re-entered); no back-to-back within one cycle.
REQ-020 SHALL compute addr+beat in 8 bits, wrap modulo WORDS.

Reset
REQ-021 SHALL on i_rst=1 immediately force state IDLE, beat 0, o_sresp_valid=0, o_sresp=0, o_sid=0, o_serror=0, o_sdata=0, o_sresp_last=0.
REQ-022 SHALL leave storage contents uninitialized by reset (no reset on memory array).
REQ-023 SHALL on reset mid-operation abandon the command: no further data accepted or response driven until a new command.

Configuration
REQ-024 SHALL provide macro PZCOREBUS_MEMORY_RESPONDER_ERROR_CHECK_EN.
REQ-025 SHALL with the macro defined flag any command where addr+length >= WORDS (9-bit compare): write beats consumed but discarded, read beats return o_sdata=0, all response beats o_serror=1.
REQ-026 SHALL without the macro wrap addresses per REQ-020 and tie o_serror=0 (except reserved command per REQ-011).

Verification
REQ-027 SHALL cover: WRITE_NON_POSTED addr=2 len=3 data A0..A3, then READ addr=2 len=3 id=5 -> write ack id matches, 4 read beats A0..A3 id=5, last on beat 3.
REQ-028 SHALL cover: READ with i_mresp_accept held 0 for 5 cycles on beat 1 -> o_sdata/o_sid/o_sresp_last unchanged, no beat skipped.
REQ-029 SHALL cover: posted WRITE len=3 with i_mdata_last=1 on beat 1 -> only 2 words written, no response, next command accepted.
REQ-030 SHALL cover: WORDS=16, READ addr=14 len=3 -> with macro 4 beats o_serror=1 data 0; without macro beats from words 14,15,0,1, o_serror=0.
REQ-031 SHALL cover: i_rst pulsed during READ beat 2 stall -> o_sresp_valid=0 same cycle, o_scmd_accept=1 after release.
REQ-032 SHALL cover: i_mcmd=3 id=9 -> single WRITE_ACK, o_serror=1, o_sid=9, no data accepted.
